// File: rtl/relobi_r_enc_cut_pkg.sv
// Shared bus configuration, R other-field packing layout and Hsiao helpers for the reliable OBI R path.
// Encoder and decoder both take their layout from here, so they cannot disagree on it.
package relobi_r_enc_cut_pkg;

    typedef struct packed {
        bit          UseAtop;
        int unsigned RUserWidth;
        int unsigned RChkWidth;
    } obi_optional_cfg_t;

    typedef struct packed {
        int unsigned       IdWidth;
        int unsigned       DataWidth;
        obi_optional_cfg_t OptionalCfg;
        bit                UseRReady;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        IdWidth:     4,
        DataWidth:   32,
        OptionalCfg: '{UseAtop: 1'b1, RUserWidth: 2, RChkWidth: 0},
        UseRReady:   1'b1
    };

    typedef struct packed {
        logic       exokay;
        logic [1:0] ruser;
        logic [0:0] rchk;
    } r_optional_default_t;

    typedef enum logic [1:0] {
        R_FIELD_RID,
        R_FIELD_EXOKAY,
        R_FIELD_RUSER,
        R_FIELD_RCHK
    } r_other_field_e;

    localparam int unsigned HsiaoMaxK = 16;

    function automatic int unsigned relobi_r_other_width(obi_cfg_t cfg);
        return cfg.IdWidth + (cfg.OptionalCfg.UseAtop ? 32'd1 : 32'd0)
             + cfg.OptionalCfg.RUserWidth + cfg.OptionalCfg.RChkWidth;
    endfunction

    // LSB position of each field; rid sits on top, rchk at bit 0.
    function automatic int unsigned relobi_r_other_offset(obi_cfg_t cfg, r_other_field_e field);
        int unsigned rchk_w  = cfg.OptionalCfg.RChkWidth;
        int unsigned ruser_w = cfg.OptionalCfg.RUserWidth;
        int unsigned atop_w  = cfg.OptionalCfg.UseAtop ? 32'd1 : 32'd0;
        case (field)
            R_FIELD_RCHK:   return 0;
            R_FIELD_RUSER:  return rchk_w;
            R_FIELD_EXOKAY: return rchk_w + ruser_w;
            default:        return rchk_w + ruser_w + atop_w;
        endcase
    endfunction

    // Smallest K with enough odd-weight (>=3) columns for n data bits.
    function automatic int unsigned hsiao_ecc_width(int unsigned n);
        int unsigned k = 2;
        while ((32'd1 << (k - 1)) < n + k) k++;
        return k;
    endfunction

    function automatic int unsigned relobi_r_other_ecc_width(obi_cfg_t cfg);
        return hsiao_ecc_width(relobi_r_other_width(cfg));
    endfunction

    // Column idx of the parity matrix: odd weights ascending, then numeric order.
    function automatic logic [HsiaoMaxK-1:0] hsiao_column(int unsigned idx, int unsigned k);
        int unsigned          seen  = 0;
        bit                   found = 1'b0;
        logic [HsiaoMaxK-1:0] col   = '0;
        for (int unsigned w = 3; w <= k; w += 2) begin
            for (int unsigned v = 0; v < (32'd1 << k); v++) begin
                if ($countones(v) == w) begin
                    if (!found && seen == idx) begin
                        col   = v[HsiaoMaxK-1:0];
                        found = 1'b1;
                    end
                    seen++;
                end
            end
        end
        return col;
    endfunction

endpackage

// File: rtl/relobi_r_enc_cut_encoder.sv
// Combinational packer plus Hsiao check-bit generator for the R other-fields (rid/exokay/ruser/rchk).
// Mirror of the manager-side R-other decoder; reusable by any R-path stage.
module relobi_r_other_encoder
    import relobi_r_enc_cut_pkg::*;
#(
    parameter obi_cfg_t    Cfg          = ObiDefaultConfig,
    parameter type         r_optional_t = r_optional_default_t,
    parameter int unsigned OtherWidth   = relobi_r_other_width(Cfg),
    parameter int unsigned EccWidth     = relobi_r_other_ecc_width(Cfg)
) (
    input  logic [Cfg.IdWidth-1:0] rid,
    input  r_optional_t            r_optional,
    output logic [OtherWidth-1:0]  other,
    output logic [EccWidth-1:0]    ecc
);
    localparam int unsigned OffRid    = relobi_r_other_offset(Cfg, R_FIELD_RID);
    localparam int unsigned OffExokay = relobi_r_other_offset(Cfg, R_FIELD_EXOKAY);
    localparam int unsigned OffRuser  = relobi_r_other_offset(Cfg, R_FIELD_RUSER);
    localparam int unsigned OffRchk   = relobi_r_other_offset(Cfg, R_FIELD_RCHK);

    logic [EccWidth-1:0] terms [OtherWidth];
    logic                unused_opt;

    assign other[OffRid +: Cfg.IdWidth] = rid;
    assign unused_opt = ^r_optional;

    if (Cfg.OptionalCfg.UseAtop) begin : g_exokay
        assign other[OffExokay] = r_optional.exokay;
    end
    for (genvar gi = 0; gi < int'(Cfg.OptionalCfg.RUserWidth); gi++) begin : g_ruser
        assign other[OffRuser + gi] = r_optional.ruser[gi];
    end
    for (genvar gi = 0; gi < int'(Cfg.OptionalCfg.RChkWidth); gi++) begin : g_rchk
        assign other[OffRchk + gi] = r_optional.rchk[gi];
    end

    for (genvar gi = 0; gi < int'(OtherWidth); gi++) begin : g_col
        localparam logic [HsiaoMaxK-1:0] Col = hsiao_column(gi, EccWidth);
        assign terms[gi] = other[gi] ? Col[EccWidth-1:0] : '0;
    end

    always_comb begin
        ecc = '0;
        for (int i = 0; i < int'(OtherWidth); i++) ecc = ecc ^ terms[i];
    end

endmodule

// File: rtl/relobi_r_enc_cut.sv
// Subordinate-side R stage: ECC-encodes the R other-fields, buffers beats in a 2-entry skid buffer,
// and presents them from a head register so no output depends combinationally on any input.
module relobi_r_enc_cut
    import relobi_r_enc_cut_pkg::*;
#(
    parameter obi_cfg_t    Cfg           = ObiDefaultConfig,
    parameter type         r_optional_t  = r_optional_default_t,
    parameter int unsigned OtherEccWidth = relobi_r_other_ecc_width(Cfg)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_rvalid_i,
    output logic                     in_rready_o,
    input  logic [Cfg.DataWidth-1:0] in_rdata_i,
    input  logic                     in_err_i,
    input  logic [Cfg.IdWidth-1:0]   in_rid_i,
    input  r_optional_t              in_r_optional_i,
    output logic                     out_rvalid_o,
    input  logic                     out_rready_i,
    output logic [Cfg.DataWidth-1:0] out_rdata_o,
    output logic                     out_err_o,
    output logic [Cfg.IdWidth-1:0]   out_rid_o,
    output r_optional_t              out_r_optional_o,
    output logic [OtherEccWidth-1:0] out_other_ecc_o
);
    localparam int unsigned OtherWidth  = relobi_r_other_width(Cfg);
    localparam int unsigned EntryWidth  = Cfg.DataWidth + 1 + OtherWidth + OtherEccWidth;
    localparam int unsigned OffRid      = relobi_r_other_offset(Cfg, R_FIELD_RID);
    localparam int unsigned OffExokay   = relobi_r_other_offset(Cfg, R_FIELD_EXOKAY);
    localparam int unsigned OffRuser    = relobi_r_other_offset(Cfg, R_FIELD_RUSER);
    localparam int unsigned OffRchk     = relobi_r_other_offset(Cfg, R_FIELD_RCHK);
    localparam int unsigned RUserFieldW = $bits(out_r_optional_o.ruser);
    localparam int unsigned RChkFieldW  = $bits(out_r_optional_o.rchk);
    localparam logic [OtherWidth-1:0] RUserMask = (OtherWidth'(1) << Cfg.OptionalCfg.RUserWidth) - 1'b1;
    localparam logic [OtherWidth-1:0] RChkMask  = (OtherWidth'(1) << Cfg.OptionalCfg.RChkWidth) - 1'b1;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [OtherWidth-1:0]    enc_other;
    logic [OtherEccWidth-1:0] enc_ecc;
    logic [EntryWidth-1:0]    in_entry;
    logic [EntryWidth-1:0]    head_reg, head_next;
    logic [EntryWidth-1:0]    tail_reg, tail_next;
    logic [1:0]               state_reg, state_next;
    logic [OtherWidth-1:0]    head_other;
    logic                     out_rready_eff;
    logic                     push;
    logic                     pop;

    relobi_r_other_encoder #(
        .Cfg          (Cfg),
        .r_optional_t (r_optional_t),
        .OtherWidth   (OtherWidth),
        .EccWidth     (OtherEccWidth)
    ) u_encoder (
        .rid        (in_rid_i),
        .r_optional (in_r_optional_i),
        .other      (enc_other),
        .ecc        (enc_ecc)
    );

    // Encoding before storage keeps the buffered copy ECC-protected.
    assign in_entry       = {in_rdata_i, in_err_i, enc_other, enc_ecc};
    assign out_rready_eff = Cfg.UseRReady ? out_rready_i : 1'b1;
    assign in_rready_o    = (state_reg != ST_TWO);
    assign out_rvalid_o   = (state_reg != ST_EMPTY);
    assign push           = in_rvalid_i & in_rready_o;
    assign pop            = out_rvalid_o & out_rready_eff;

    always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        tail_next  = tail_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (push) begin
                    head_next  = in_entry;
                    state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_next = in_entry;
                end else if (push) begin
                    tail_next  = in_entry;
                    state_next = ST_TWO;
                end else if (pop) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    head_next  = tail_reg;
                    state_next = ST_ONE;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_EMPTY;
            head_reg  <= '0;
            tail_reg  <= '0;
        end else begin
            state_reg <= state_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
        end
    end

    assign {out_rdata_o, out_err_o, head_other, out_other_ecc_o} = head_reg;
    assign out_rid_o = head_other[OffRid +: Cfg.IdWidth];

    // Absent optional fields come out as zero through the masks.
    always_comb begin
        out_r_optional_o        = '0;
        out_r_optional_o.exokay = Cfg.OptionalCfg.UseAtop ? head_other[OffExokay] : 1'b0;
        out_r_optional_o.ruser  = RUserFieldW'((head_other >> OffRuser) & RUserMask);
        out_r_optional_o.rchk   = RChkFieldW'((head_other >> OffRchk) & RChkMask);
    end

endmodule

// File: tb/tb_relobi_r_enc_cut.sv
// Directed bench for relobi_r_enc_cut: table of beats with hand-computed Hsiao check bits,
// a small reference decoder for single-bit correction, and sequences for stall, reset and no-ready config.
module tb_relobi_r_enc_cut;
    import relobi_r_enc_cut_pkg::*;

    localparam obi_cfg_t CfgMain = ObiDefaultConfig;
    localparam obi_cfg_t CfgNr = '{
        IdWidth:     4,
        DataWidth:   32,
        OptionalCfg: '{UseAtop: 1'b1, RUserWidth: 2, RChkWidth: 0},
        UseRReady:   1'b0
    };

    typedef struct {
        logic [3:0]  rid;
        logic        exokay;
        logic [1:0]  ruser;
        logic [31:0] rdata;
        logic        err;
        logic [4:0]  ecc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                in_rvalid, in_rready, in_err, out_rvalid, out_rready, out_err;
    logic [31:0]         in_rdata, out_rdata;
    logic [3:0]          in_rid, out_rid;
    r_optional_default_t in_opt, out_opt;
    logic [4:0]          out_ecc;

    logic                nr_in_rvalid, nr_in_rready, nr_in_err, nr_out_rvalid, nr_out_rready, nr_out_err;
    logic [31:0]         nr_in_rdata, nr_out_rdata;
    logic [3:0]          nr_in_rid, nr_out_rid;
    r_optional_default_t nr_in_opt, nr_out_opt;
    logic [4:0]          nr_out_ecc;

    relobi_r_enc_cut #(.Cfg(CfgMain), .r_optional_t(r_optional_default_t)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_rvalid_i(in_rvalid), .in_rready_o(in_rready), .in_rdata_i(in_rdata),
        .in_err_i(in_err), .in_rid_i(in_rid), .in_r_optional_i(in_opt),
        .out_rvalid_o(out_rvalid), .out_rready_i(out_rready), .out_rdata_o(out_rdata),
        .out_err_o(out_err), .out_rid_o(out_rid), .out_r_optional_o(out_opt),
        .out_other_ecc_o(out_ecc)
    );

    relobi_r_enc_cut #(.Cfg(CfgNr), .r_optional_t(r_optional_default_t)) dut_nr (
        .clk_i(clk), .rst_ni(rst_n),
        .in_rvalid_i(nr_in_rvalid), .in_rready_o(nr_in_rready), .in_rdata_i(nr_in_rdata),
        .in_err_i(nr_in_err), .in_rid_i(nr_in_rid), .in_r_optional_i(nr_in_opt),
        .out_rvalid_o(nr_out_rvalid), .out_rready_i(nr_out_rready), .out_rdata_o(nr_out_rdata),
        .out_err_o(nr_out_err), .out_rid_o(nr_out_rid), .out_r_optional_o(nr_out_opt),
        .out_other_ecc_o(nr_out_ecc)
    );

    int   total  = 0;
    int   passed = 0;
    vec_t vecs [10];
    vec_t v1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    function automatic logic [63:0] exp_beat(input vec_t v);
        return 64'({v.rid, v.exokay, v.ruser, 1'b0, v.rdata, v.err, v.ecc});
    endfunction

    function automatic logic [63:0] got_beat();
        return 64'({out_rid, out_opt.exokay, out_opt.ruser, out_opt.rchk, out_rdata, out_err, out_ecc});
    endfunction

    function automatic logic [63:0] got_beat_nr();
        return 64'({nr_out_rid, nr_out_opt.exokay, nr_out_opt.ruser, nr_out_opt.rchk,
                    nr_out_rdata, nr_out_err, nr_out_ecc});
    endfunction

    // Parity-matrix columns for packed bits 0..6 (ruser0, ruser1, exokay, rid0..rid3).
    function automatic logic [4:0] hcol(input int i);
        case (i)
            0: return 5'h07;
            1: return 5'h0B;
            2: return 5'h0D;
            3: return 5'h0E;
            4: return 5'h13;
            5: return 5'h15;
            default: return 5'h16;
        endcase
    endfunction

    function automatic logic [6:0] ref_decode(input logic [6:0] p, input logic [4:0] e);
        logic [4:0] syn = e;
        logic [6:0] fixed = p;
        for (int i = 0; i < 7; i++) if (p[i]) syn = syn ^ hcol(i);
        for (int i = 0; i < 7; i++) if (syn == hcol(i)) fixed[i] = ~fixed[i];
        return fixed;
    endfunction

    task automatic drive(input vec_t v);
        in_rvalid = 1'b1; in_rid = v.rid; in_rdata = v.rdata; in_err = v.err;
        in_opt = '0; in_opt.exokay = v.exokay; in_opt.ruser = v.ruser;
    endtask

    task automatic drive_nr(input vec_t v);
        nr_in_rvalid = 1'b1; nr_in_rid = v.rid; nr_in_rdata = v.rdata; nr_in_err = v.err;
        nr_in_opt = '0; nr_in_opt.exokay = v.exokay; nr_in_opt.ruser = v.ruser;
    endtask

    initial begin
        logic [4:0]  ecc_tab [10];
        logic [11:0] cw;
        logic [11:0] flip;
        ecc_tab = '{5'h0D, 5'h09, 5'h18, 5'h1C, 5'h15, 5'h1C, 5'h00, 5'h04, 5'h16, 5'h12};
        for (int i = 0; i < 10; i++) begin
            vecs[i].rid    = 4'(i);
            vecs[i].exokay = (i % 3 == 0);
            vecs[i].ruser  = 2'(i % 4);
            vecs[i].rdata  = 32'hA5A5_0000 + 32'(i) * 32'h111;
            vecs[i].err    = (i % 2 == 1);
            vecs[i].ecc    = ecc_tab[i];
        end
        v1 = '{rid: 4'h5, exokay: 1'b1, ruser: 2'b10, rdata: 32'hDEADBEEF, err: 1'b0, ecc: 5'h1D};

        rst_n = 1'b0;
        in_rvalid = 0; in_rid = 0; in_rdata = 0; in_err = 0; in_opt = '0; out_rready = 1'b1;
        nr_in_rvalid = 0; nr_in_rid = 0; nr_in_rdata = 0; nr_in_err = 0; nr_in_opt = '0; nr_out_rready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset_rvalid", 64'(out_rvalid), 64'd0);
        check("reset_rready", 64'(in_rready), 64'd1);
        check("reset_fields", got_beat(), 64'd0);

        // 1: single beat, one-cycle latency, reference decode
        drive(v1);
        @(negedge clk);
        check("t1_rvalid", 64'(out_rvalid), 64'd1);
        check("t1_beat", got_beat(), exp_beat(v1));
        cw = {out_rid, out_opt.exokay, out_opt.ruser, out_ecc};
        in_rvalid = 1'b0;
        check("t1_decode", 64'(ref_decode(cw[11:5], cw[4:0])), 64'h2E);
        // 4: every single-bit flip of packed field or ECC is corrected
        for (int b = 0; b < 12; b++) begin
            flip = cw ^ (12'd1 << b);
            check($sformatf("t4_flip%0d", b), 64'(ref_decode(flip[11:5], flip[4:0])), 64'h2E);
        end
        @(negedge clk);
        check("t1_drained", 64'(out_rvalid), 64'd0);

        // 2: ten back-to-back beats
        for (int i = 0; i <= 10; i++) begin
            check($sformatf("t2_rready%0d", i), 64'(in_rready), 64'd1);
            if (i > 0) check($sformatf("t2_beat%0d", i - 1), 64'({out_rvalid, got_beat()}), {1'b1, exp_beat(vecs[i-1])});
            if (i < 10) drive(vecs[i]);
            else in_rvalid = 1'b0;
            @(negedge clk);
        end
        check("t2_drained", 64'(out_rvalid), 64'd0);

        // 3: downstream stall, two beats accepted, third held off
        out_rready = 1'b0;
        drive(vecs[1]);
        @(negedge clk);
        check("t3_rready_one", 64'(in_rready), 64'd1);
        check("t3_head1_a", 64'({out_rvalid, got_beat()}), {1'b1, exp_beat(vecs[1])});
        drive(vecs[2]);
        @(negedge clk);
        check("t3_rready_full", 64'(in_rready), 64'd0);
        check("t3_head1_b", got_beat(), exp_beat(vecs[1]));
        drive(vecs[3]);
        @(negedge clk);
        check("t3_rready_held", 64'(in_rready), 64'd0);
        check("t3_head1_c", got_beat(), exp_beat(vecs[1]));
        out_rready = 1'b1;
        @(negedge clk);
        check("t3_head2", got_beat(), exp_beat(vecs[2]));
        check("t3_rready_back", 64'(in_rready), 64'd1);
        @(negedge clk);
        check("t3_head3", 64'({out_rvalid, got_beat()}), {1'b1, exp_beat(vecs[3])});
        in_rvalid = 1'b0;
        @(negedge clk);
        check("t3_drained", 64'(out_rvalid), 64'd0);

        // 5: asynchronous reset with two beats buffered
        out_rready = 1'b0;
        drive(vecs[4]);
        @(negedge clk);
        drive(vecs[5]);
        @(negedge clk);
        check("t5_full", 64'(in_rready), 64'd0);
        in_rvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_rvalid", 64'(out_rvalid), 64'd0);
        check("t5_rst_rready", 64'(in_rready), 64'd1);
        check("t5_rst_fields", got_beat(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_rready = 1'b1;
        @(negedge clk);
        check("t5_no_stale", 64'(out_rvalid), 64'd0);
        drive(vecs[6]);
        @(negedge clk);
        check("t5_fresh", 64'({out_rvalid, got_beat()}), {1'b1, exp_beat(vecs[6])});
        in_rvalid = 1'b0;
        @(negedge clk);

        // 6: UseRReady=0, continuous stream, out_rready input held low and ignored
        for (int i = 0; i <= 10; i++) begin
            check($sformatf("t6_rready%0d", i), 64'(nr_in_rready), 64'd1);
            if (i > 0) check($sformatf("t6_beat%0d", i - 1), 64'({nr_out_rvalid, got_beat_nr()}), {1'b1, exp_beat(vecs[i-1])});
            if (i < 10) drive_nr(vecs[i]);
            else nr_in_rvalid = 1'b0;
            @(negedge clk);
        end
        check("t6_drained", 64'(nr_out_rvalid), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
